// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The optional checksum trailer is enabled with INSTR_LOADER_CHECKSUM_EN.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned DEF_MEM_DEPTH  = 100;
    localparam int unsigned DEF_BASE_ADR   = 0;
    localparam int unsigned DEF_LEN_W      = 16;

    // States in which the loader pulls bytes from the receiver.
    function automatic logic rx_open(state_e s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_CHK) || (s == S_ERR);
    endfunction

    function automatic logic is_busy(state_e s);
        return (s == S_LEN) || (s == S_DATA) || (s == S_WRITE) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Packs big-endian bytes into 32-bit words; word_valid_o flags the byte that completes a word.
module instr_loader_byte_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [23:0] sh_q;
    logic [1:0]  cnt_q;

    // The fourth byte is taken straight from the input so the word is ready on its handshake.
    assign word_o       = {sh_q, in_byte_i};
    assign word_valid_o = in_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (in_valid_i) begin
            sh_q  <= {sh_q[15:0], in_byte_i};
            cnt_q <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it word by word into memory,
// then releases the core. Define INSTR_LOADER_CHECKSUM_EN for the trailing XOR checksum byte.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int unsigned BASE_ADR  = DEF_BASE_ADR,
    parameter int unsigned LEN_W     = DEF_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_valid_i,
    output logic             rx_ready_o,
    output logic             instr_en_o,
    output logic [31:0]      mem_adr_o,
    output logic [31:0]      mem_in_o,
    output logic             cpu_res_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] word_cnt_o
);

    localparam int unsigned LenBytes = LEN_W / 8;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_e SEnd = S_CHK;
`else
    localparam state_e SEnd = S_DONE;
`endif

    state_e           state_q, state_d;
    logic             rx_ready_q, instr_en_q, cpu_res_q, busy_q, done_q, err_q;
    logic [31:0]      adr_q, mem_in_q;
    logic [LEN_W-1:0] len_q, cnt_q, len_next, cnt_inc;
    logic [7:0]       len_cnt_q;
    logic             accept, start_ok, len_last, asm_valid, word_valid;
    logic [31:0]      word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    assign accept   = rx_valid_i && rx_ready_q;
    assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                  (state_q == S_ERR));
    assign len_last = (len_cnt_q == 8'(LenBytes - 1));
    assign cnt_inc  = cnt_q + LEN_W'(1);

    if (LEN_W == 8) begin : g_len_one
        assign len_next = rx_data_i;
    end else begin : g_len_multi
        assign len_next = {len_q[LEN_W-9:0], rx_data_i};
    end

    assign asm_valid = accept && (state_q == S_DATA);

    instr_loader_byte_assembler u_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clr_i        (start_ok),
        .in_valid_i   (asm_valid),
        .in_byte_i    (rx_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN;
            end
            S_LEN: begin
                if (accept && len_last) begin
                    if (len_next == '0)                  state_d = SEnd;
                    else if (32'(len_next) > MEM_DEPTH)  state_d = S_ERR;
                    else                                 state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = (cnt_inc == len_q) ? SEnd : S_DATA;
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            instr_en_q <= 1'b0;
            cpu_res_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= '0;
            mem_in_q   <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            len_cnt_q  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_open(state_d);
            instr_en_q <= (state_d == S_WRITE);
            busy_q     <= is_busy(state_d);
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
            cpu_res_q  <= (state_d == S_DONE);
            if (start_ok) begin
                adr_q     <= 32'(BASE_ADR);
                len_q     <= '0;
                cnt_q     <= '0;
                len_cnt_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum_q    <= '0;
`endif
            end
            if (accept && (state_q == S_LEN)) begin
                len_q     <= len_next;
                len_cnt_q <= len_cnt_q + 8'd1;
            end
            if (word_valid) mem_in_q <= word;
`ifdef INSTR_LOADER_CHECKSUM_EN
            if (asm_valid) csum_q <= csum_q ^ rx_data_i;
`endif
            if (state_q == S_WRITE) begin
                adr_q <= adr_q + 32'd1;
                cnt_q <= cnt_inc;
            end
        end
    end

    assign rx_ready_o = rx_ready_q;
    assign instr_en_o = instr_en_q;
    assign mem_adr_o  = adr_q;
    assign mem_in_o   = mem_in_q;
    assign cpu_res_o  = cpu_res_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed/randomised bench for instr_loader; expected memory images come from the word lists.
// Define INSTR_LOADER_CHECKSUM_EN to build and exercise the checksum trailer.
module tb_instr_loader;

    localparam int unsigned MEM_DEPTH = 100;
    localparam int unsigned BASE      = 0;
    localparam int unsigned LEN_W     = 16;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic             clk = 1'b0;
    logic             rst_n, start, rx_valid, rx_ready, instr_en, cpu_res, busy, done, err;
    logic [7:0]       rx_data;
    logic [31:0]      mem_adr, mem_in;
    logic [LEN_W-1:0] word_cnt;

    int checks = 0;
    int errors = 0;
    int nwr    = 0;
    logic        prev_en = 1'b0;
    logic [31:0] cap [0:127];

    always #5 clk = ~clk;

    instr_loader #(
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADR  (BASE),
        .LEN_W     (LEN_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .instr_en_o (instr_en),
        .mem_adr_o  (mem_adr),
        .mem_in_o   (mem_in),
        .cpu_res_o  (cpu_res),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .word_cnt_o (word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory-side observer: captures every write and checks write-cycle invariants.
    always @(negedge clk) begin
        if (rst_n && instr_en) begin
            chk("wr_rx_ready", {31'b0, rx_ready}, 32'd0);
            chk("wr_back_to_back", {31'b0, prev_en}, 32'd0);
            chk("wr_adr_range", {31'b0, mem_adr < 32'(BASE + MEM_DEPTH)}, 32'd1);
            if (mem_adr < 32'd128) cap[mem_adr[6:0]] = mem_in;
            nwr++;
        end
        prev_en = rst_n & instr_en;
    end

    function automatic bq_t make_frame(input wq_t w, input logic [15:0] n);
        bq_t f;
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
`endif
        f.push_back(n[15:8]);
        f.push_back(n[7:0]);
        foreach (w[i]) begin
            for (int b = 3; b >= 0; b--) begin
                f.push_back(w[i][8*b +: 8]);
`ifdef INSTR_LOADER_CHECKSUM_EN
                x = x ^ w[i][8*b +: 8];
`endif
            end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        f.push_back(x);
`endif
        return f;
    endfunction

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int i = 0; i < n; i++) w.push_back($urandom);
        return w;
    endfunction

    task automatic clear_cap();
        foreach (cap[i]) cap[i] = 'x;
        nwr = 0;
    endtask

    task automatic pulse_start();
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Offer one byte and return at the negedge following its handshake.
    task automatic send(input logic [7:0] b, input bit gaps);
        int budget;
        while (gaps && ($urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        budget   = 20;
        while ((rx_ready !== 1'b1) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        chk("rx_accept", {31'b0, rx_ready}, 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int b = budget;
        while (!(done || err) && (b > 0)) begin
            @(negedge clk);
            b--;
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_flags"}, {26'b0, rx_ready, instr_en, busy, done, err, cpu_res}, 32'd0);
        chk({tag, "_adr"}, mem_adr, 32'd0);
        chk({tag, "_din"}, mem_in, 32'd0);
        chk({tag, "_cnt"}, 32'(word_cnt), 32'd0);
    endtask

    task automatic run_load(input wq_t w, input bit gaps, input bit mid_start,
                            input string tag);
        bq_t f;
        f = make_frame(w, 16'(w.size()));
        clear_cap();
        pulse_start();
        foreach (f[i]) begin
            if (mid_start && (i == 6)) pulse_start();
            send(f[i], gaps);
        end
        wait_end(4);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_cpu_res"}, {31'b0, cpu_res}, 32'd1);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(w.size()));
        chk({tag, "_nwr"}, nwr, 32'(w.size()));
        foreach (w[i]) chk({tag, "_mem"}, cap[BASE + i], w[i]);
    endtask

    initial begin
        bq_t f;
        wq_t w;
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        clear_cap();
        repeat (3) @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Idle: bytes are not taken.
        rx_valid = 1'b1; rx_data = 8'h5A;
        @(negedge clk);
        chk("idle_rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        rx_valid = 1'b0;

        // Two-word image, back-to-back bytes, with latency checks.
        w = '{32'hDEADBEEF, 32'h01234567};
        f = make_frame(w, 16'd2);
        clear_cap();
        pulse_start();
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_cpu_res_load", {31'b0, cpu_res}, 32'd0);
        foreach (f[i]) begin
            send(f[i], 1'b0);
            if (i == 5) begin
                chk("t1_lat0_en", {31'b0, instr_en}, 32'd1);
                chk("t1_lat0_adr", mem_adr, 32'(BASE));
                chk("t1_lat0_din", mem_in, 32'hDEADBEEF);
            end
            if (i == 9) begin
                chk("t1_lat1_en", {31'b0, instr_en}, 32'd1);
                chk("t1_lat1_adr", mem_adr, 32'(BASE + 1));
            end
        end
        wait_end(4);
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_cpu_res", {31'b0, cpu_res}, 32'd1);
        chk("t1_word_cnt", 32'(word_cnt), 32'd2);
        chk("t1_nwr", nwr, 32'd2);
        chk("t1_mem0", cap[BASE], 32'hDEADBEEF);
        chk("t1_mem1", cap[BASE + 1], 32'h01234567);
        rx_valid = 1'b1;
        @(negedge clk);
        chk("done_rx_ready", {31'b0, rx_ready}, 32'd0);
        rx_valid = 1'b0;

        // Empty image.
        w = {};
        f = make_frame(w, 16'd0);
        clear_cap();
        pulse_start();
        foreach (f[i]) send(f[i], 1'b0);
        wait_end(3);
        chk("t2_done", {31'b0, done}, 32'd1);
        chk("t2_nwr", nwr, 32'd0);
        chk("t2_word_cnt", 32'(word_cnt), 32'd0);

        // Oversize length goes to ERR, which then drains bytes.
        clear_cap();
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h65, 1'b0);
        wait_end(3);
        chk("t3_err", {31'b0, err}, 32'd1);
        chk("t3_done", {31'b0, done}, 32'd0);
        chk("t3_cpu_res", {31'b0, cpu_res}, 32'd0);
        chk("t3_busy", {31'b0, busy}, 32'd0);
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b1);
        chk("t3_err_hold", {31'b0, err}, 32'd1);
        chk("t3_nwr", nwr, 32'd0);
        run_load(rand_words(3), 1'b0, 1'b0, "t3_reload");

        // Gappy valid, ignored mid-load start, random sizes, and the full-depth image.
        run_load(rand_words(3), 1'b1, 1'b0, "t4_gaps");
        run_load(rand_words(3), 1'b1, 1'b1, "t4_midstart");
        for (int k = 0; k < 4; k++) run_load(rand_words($urandom_range(1, 6)), 1'b1, 1'b0, "t4_rand");
        run_load(rand_words(MEM_DEPTH), 1'b0, 1'b0, "t4_full");

        // Reset in the middle of the second word.
        w = rand_words(2);
        f = make_frame(w, 16'd2);
        clear_cap();
        pulse_start();
        for (int i = 0; i < 8; i++) send(f[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("t5_midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(rand_words(1), 1'b0, 1'b0, "t5_after");

`ifdef INSTR_LOADER_CHECKSUM_EN
        w = '{32'h11223344};
        run_load(w, 1'b0, 1'b0, "t6_csum_ok");
        f = make_frame(w, 16'd1);
        f[f.size() - 1] = f[f.size() - 1] ^ 8'h01;
        clear_cap();
        pulse_start();
        foreach (f[i]) send(f[i], 1'b0);
        wait_end(3);
        chk("t6_csum_bad_err", {31'b0, err}, 32'd1);
        chk("t6_csum_bad_cpu_res", {31'b0, cpu_res}, 32'd0);
        chk("t6_csum_bad_nwr", nwr, 32'd1);
        chk("t6_csum_bad_mem", cap[BASE], 32'h11223344);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction/data memory.
- Accepts a byte stream from a serial receiver (valid/ready) and assembles bytes into 32-bit words.
- Drives the memory's load port (instr_en, mem_adr, mem_in) to write those words into consecutive addresses.
- Holds the core in reset until the image is fully written, then releases it.

Parameters:
- MEM_DEPTH, 100: memory depth in words; the largest legal image length.
- BASE_ADR, 0: word address of the first loaded word.
- LEN_W, 16: width of the image length header, in bits; always a multiple of 8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- res  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when the FSM is in IDLE, DONE or ERR.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid this cycle.
- rx_ready  output  1  loader accepts the byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
- instr_en  output  1  memory write strobe for the load port.
- mem_adr  output  32  word address for the load write.
- mem_in  output  32  word to write.
- cpu_res  output  1  active-low reset to the core; 0 while loading.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed successfully; sticky.
- err  output  1  the last load failed; sticky.
- word_cnt  output  LEN_W  number of words written so far in the current load.

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE; rx_ready=0, instr_en=0, mem_adr=0, mem_in=0, busy=0, done=0, err=0, word_cnt=0; cpu_res=0.
  - Reset mid-load aborts immediately; the partially written memory is left as is.
- Frame format: LEN_W/8 length bytes, MSB first, giving N words; then 4*N data bytes, each word MSB first (big-endian).
- FSM states: IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
- IDLE/DONE/ERR with start=1: go to LEN; clear done, err and word_cnt; set busy=1 and cpu_res=0; load the address counter with BASE_ADR.
- start while busy=1 is ignored.
- LEN: rx_ready=1; shift in the length bytes.
  - After the last length byte: N=0 goes to DONE (or CHK with the optional feature); N>MEM_DEPTH goes to ERR; otherwise go to DATA.
- DATA: rx_ready=1; shift each byte into a 32-bit assembly register, using a 2-bit byte counter.
  - When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - instr_en=1, mem_in=assembled word, mem_adr=current address, rx_ready=0.
  - Next cycle: address+1 and word_cnt+1.
  - If word_cnt+1==N, go to DONE (or CHK); otherwise go to DATA.
- Latency: instr_en is asserted in the cycle after the handshake that carries the 4th byte of a word. Maximum throughput is one word per 5 cycles.
- instr_en is never high in any state other than WRITE, and is never high on two consecutive cycles.
- rx_valid=0 stalls the FSM in its current state, with no timeout.
- DONE: busy=0, done=1, cpu_res=1; rx_ready=0.
- ERR: busy=0, err=1, cpu_res stays 0; rx_ready=1 and accepted bytes are discarded (drained) until the next start.
- Bytes arriving in IDLE/DONE are not accepted (rx_ready=0).
- The address counter is 32-bit; it cannot wrap, because N≤MEM_DEPTH.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - The frame carries one extra trailing byte, equal to the XOR of all data bytes (length bytes excluded).
  - After the last WRITE, or directly after LEN when N=0, the FSM enters CHK and accepts that byte.
  - Match: go to DONE. Mismatch: go to ERR, with cpu_res held at 0. Words already written remain in memory.
- Undefined: no CHK state, no checksum byte; DONE follows the last WRITE directly.

Decomposition:
- Package instr_loader_pkg holds:
  - state encoding constants (S_IDLE…S_ERR, 3-bit);
  - BYTES_PER_WORD=4;
  - default MEM_DEPTH/BASE_ADR.
- One natural sub-module: byte_assembler. It holds the 4-byte shift register and byte counter, and outputs word[31:0] and word_valid; the parent FSM clears it on start.

Test Plan:
- Reset then start; stream 00 02 | DE AD BE EF | 01 23 45 67 with rx_valid always high -> instr_en pulses twice; (mem_adr,mem_in)=(0,0xDEADBEEF) then (1,0x01234567); word_cnt=2; done=1, cpu_res=1.
- start with length 00 00 -> no instr_en pulse; done=1 within 3 cycles of the last length byte.
- Length 00 65 (101) with MEM_DEPTH=100 -> err=1, cpu_res=0, no writes; the following 8 bytes are accepted and dropped; a new start then loads correctly.
- Random rx_valid gaps (50% duty) during a 3-word image -> identical memory contents; rx_ready=0 during each WRITE cycle.
- Assert res low after 2 bytes of the second word -> all outputs are reset values in the same cycle; a subsequent clean load starts at BASE_ADR.
- With INSTR_LOADER_CHECKSUM_EN: image 00 01 | 11 22 33 44 plus checksum 0x44 -> done=1; the same image with checksum 0x45 -> err=1, one word written.
